// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding and load-use hazard control for the MIPS pipeline.
//
// In-flight register writers are tracked as tags {valid, wr_en, addr, is_load} in an EX slot
// followed by DEPTH post-EX entries (entry0 = EX/MEM, entry1 = MEM/WB, ...). A load result is
// forwardable from entry LOAD_STAGE onwards; ALU results are forwardable from entry0.
//
// Build option: define ID_FWD_EN to enable ID-stage Rs forwarding for JR/JALR/branches.
// Without it id_fwd_rs_sel is tied to 0 and an early Rs read waits until no tracked tag
// matches id_rs, i.e. until the producer has been written back to the register file.
module fwd_hazard_unit #(
  parameter int  AW         = 5,
  parameter int  DEPTH      = 3,
  parameter int  LOAD_STAGE = 1,
  parameter int  CNT_W      = 16,
  localparam int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pipe_hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_early_rs,
  input  logic             id_wr_en,
  input  logic [AW-1:0]    id_wr_addr,
  input  logic             id_is_load,
  output logic             stall,
  output logic             bubble,
  output logic [SEL_W-1:0] ex_fwd_rs_sel,
  output logic [SEL_W-1:0] ex_fwd_rt_sel,
  output logic [SEL_W-1:0] id_fwd_rs_sel,
  output logic [CNT_W-1:0] stall_count
);

  // EX slot: destination tag plus the instruction's own source operands
  logic                      ex_valid;
  logic                      ex_wr_en;
  logic                      ex_is_load;
  logic [AW-1:0]             ex_addr;
  logic                      ex_use_rs;
  logic                      ex_use_rt;
  logic [AW-1:0]             ex_rs;
  logic [AW-1:0]             ex_rt;

  // Post-EX entries, index 0 is the youngest
  logic [DEPTH-1:0]          ent_valid;
  logic [DEPTH-1:0]          ent_wr_en;
  logic [DEPTH-1:0]          ent_is_load;
  logic [DEPTH-1:0][AW-1:0]  ent_addr;

  // Unified view by position: 0 = EX slot, j = entry (j-1)
  logic [DEPTH:0]            pos_live;
  logic [DEPTH:0]            pos_load;
  logic [DEPTH:0][AW-1:0]    pos_addr;

  logic                      rs_load_use;
  logic                      rt_load_use;
  logic                      early_haz;
  logic [SEL_W-1:0]          early_sel;
  logic                      id_haz;
  logic                      active;
  logic                      issue;

  // Youngest post-EX producer of src for the instruction sitting in EX; 0 when none
  function automatic logic [SEL_W-1:0] ex_source(
    input logic [AW-1:0]         src,
    input logic [DEPTH:0]        live,
    input logic [DEPTH:0][AW-1:0] addr
  );
    ex_source = '0;
    for (int j = DEPTH; j >= 1; j--) begin
      if (live[j] && (addr[j] == src)) ex_source = SEL_W'(j);
    end
  endfunction

  // An ID source must wait if its youngest producer, one cycle older, still is not ready
  function automatic logic load_use(
    input logic [AW-1:0]          src,
    input logic [DEPTH:0]         live,
    input logic [DEPTH:0]         ld,
    input logic [DEPTH:0][AW-1:0] addr
  );
    logic hit;
    hit      = 1'b0;
    load_use = 1'b0;
    for (int j = 0; j <= DEPTH; j++) begin
      if (!hit && live[j] && (addr[j] == src)) begin
        hit = 1'b1;
        // position j is projected to entry index j next cycle
        load_use = ld[j] && (j < LOAD_STAGE);
      end
    end
  endfunction

  // Flatten EX slot and entries into position-indexed vectors
  always_comb begin
    pos_live[0] = ex_valid & ex_wr_en & (ex_addr != '0);
    pos_load[0] = ex_is_load;
    pos_addr[0] = ex_addr;
    for (int i = 0; i < DEPTH; i++) begin
      pos_live[i+1] = ent_valid[i] & ent_wr_en[i] & (ent_addr[i] != '0);
      pos_load[i+1] = ent_is_load[i];
      pos_addr[i+1] = ent_addr[i];
    end
  end

  assign rs_load_use = load_use(id_rs, pos_live, pos_load, pos_addr);
  assign rt_load_use = load_use(id_rt, pos_live, pos_load, pos_addr);

`ifdef ID_FWD_EN
  logic early_hit;

  // Early Rs: youngest producer must already hold its result in a post-EX entry
  always_comb begin
    early_hit = 1'b0;
    early_haz = 1'b0;
    early_sel = '0;
    for (int j = 0; j <= DEPTH; j++) begin
      if (!early_hit && pos_live[j] && (pos_addr[j] == id_rs)) begin
        early_hit = 1'b1;
        if ((j >= 1) && (!pos_load[j] || ((j - 1) >= LOAD_STAGE))) early_sel = SEL_W'(j);
        else early_haz = 1'b1;
      end
    end
  end
`else
  // Early Rs without forwarding: wait until no tracked writer targets id_rs
  always_comb begin
    early_haz = 1'b0;
    for (int j = 0; j <= DEPTH; j++) begin
      if (pos_live[j] && (pos_addr[j] == id_rs)) early_haz = 1'b1;
    end
  end

  assign early_sel = '0;
`endif

  assign id_haz = id_valid & ((id_use_rs & rs_load_use) |
                              (id_use_rt & rt_load_use) |
                              (id_early_rs & early_haz));

  // Hold and reset silence stall/bubble; flush overrides a stall but still needs a bubble
  assign active = ~reset & ~pipe_hold;
  assign stall  = active & ~flush & id_haz;
  assign bubble = active & (flush | id_haz);
  assign issue  = id_valid & ~stall & ~flush;

  assign ex_fwd_rs_sel = (!reset && ex_valid && ex_use_rs) ?
                         ex_source(ex_rs, pos_live, pos_addr) : '0;
  assign ex_fwd_rt_sel = (!reset && ex_valid && ex_use_rt) ?
                         ex_source(ex_rt, pos_live, pos_addr) : '0;
  assign id_fwd_rs_sel = (!reset && id_valid && id_early_rs) ? early_sel : '0;

  // Tracker shift: entries age by one, EX slot takes the issuing instruction or a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_wr_en    <= 1'b0;
      ex_is_load  <= 1'b0;
      ex_addr     <= '0;
      ex_use_rs   <= 1'b0;
      ex_use_rt   <= 1'b0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ent_valid   <= '0;
      ent_wr_en   <= '0;
      ent_is_load <= '0;
      ent_addr    <= '0;
    end else if (!pipe_hold) begin
      ent_valid[0]   <= ex_valid;
      ent_wr_en[0]   <= ex_wr_en;
      ent_is_load[0] <= ex_is_load;
      ent_addr[0]    <= ex_addr;
      for (int i = 1; i < DEPTH; i++) begin
        ent_valid[i]   <= ent_valid[i-1];
        ent_wr_en[i]   <= ent_wr_en[i-1];
        ent_is_load[i] <= ent_is_load[i-1];
        ent_addr[i]    <= ent_addr[i-1];
      end
      if (issue) begin
        ex_valid   <= 1'b1;
        ex_wr_en   <= id_wr_en;
        ex_is_load <= id_is_load;
        ex_addr    <= id_wr_addr;
        ex_use_rs  <= id_use_rs;
        ex_use_rt  <= id_use_rt;
        ex_rs      <= id_rs;
        ex_rt      <= id_rt;
      end else begin
        ex_valid   <= 1'b0;
        ex_wr_en   <= 1'b0;
        ex_is_load <= 1'b0;
        ex_addr    <= '0;
        ex_use_rs  <= 1'b0;
        ex_use_rt  <= 1'b0;
        ex_rs      <= '0;
        ex_rt      <= '0;
      end
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && !pipe_hold && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Testbench for fwd_hazard_unit: directed pipeline scenarios plus a randomized run
// against an age-based reference model. A second instance (LOAD_STAGE=2, CNT_W=4)
// shares the stimulus for the longer load latency and counter saturation.
module tb_fwd_hazard_unit;
  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int LS    = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, pipe_hold, flush, id_valid;
  logic [4:0] id_rs, id_rt, id_wr_addr;
  logic       id_use_rs, id_use_rt, id_early_rs, id_wr_en, id_is_load;

  logic        stall, bubble;
  logic [1:0]  ex_rs_sel, ex_rt_sel, id_sel;
  logic [15:0] cnt;
  logic        stall_b, bubble_b;
  logic [1:0]  ex_rs_sel_b, ex_rt_sel_b, id_sel_b;
  logic [3:0]  cnt_b;

  int n_vec = 0;
  int n_err = 0;

  fwd_hazard_unit u_dut (
    .clk(clk), .reset(reset), .pipe_hold(pipe_hold), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_early_rs(id_early_rs), .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
    .id_is_load(id_is_load), .stall(stall), .bubble(bubble), .ex_fwd_rs_sel(ex_rs_sel),
    .ex_fwd_rt_sel(ex_rt_sel), .id_fwd_rs_sel(id_sel), .stall_count(cnt)
  );

  fwd_hazard_unit #(.LOAD_STAGE(2), .CNT_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .pipe_hold(pipe_hold), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_early_rs(id_early_rs), .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
    .id_is_load(id_is_load), .stall(stall_b), .bubble(bubble_b), .ex_fwd_rs_sel(ex_rs_sel_b),
    .ex_fwd_rt_sel(ex_rt_sel_b), .id_fwd_rs_sel(id_sel_b), .stall_count(cnt_b)
  );

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic early,
                       input logic wr, input logic [4:0] wa, input logic ld);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_early_rs = early; id_wr_en = wr; id_wr_addr = wa; id_is_load = ld;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; pipe_hold = 1'b0; flush = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- reference model: instructions indexed by age since entering EX
  typedef struct packed {
    logic v, wr, ld, urs, urt;
    logic [4:0] dst, rs, rt;
  } slot_t;

  slot_t       m [0:DEPTH];
  logic [15:0] m_cnt;

  function automatic int avail_age(input logic ld);
    return ld ? LS + 1 : 1;
  endfunction

  function automatic int youngest(input logic [4:0] r, input int from);
    for (int a = from; a <= DEPTH; a++)
      if (m[a].v && m[a].wr && m[a].dst != 5'd0 && m[a].dst == r) return a;
    return -1;
  endfunction

  function automatic logic late(input logic [4:0] r);
    int a;
    a = youngest(r, 0);
    return (a >= 0) && ((a + 1) < avail_age(m[a].ld));
  endfunction

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    if ({stall, bubble, ex_rs_sel, ex_rt_sel, id_sel, cnt} !== 24'd0) begin
      n_err++; $display("FAIL reset_a: got %h expected 0", {stall, bubble, ex_rs_sel, ex_rt_sel, id_sel, cnt});
    end
    n_vec++;
    if ({stall_b, bubble_b, ex_rs_sel_b, ex_rt_sel_b, id_sel_b, cnt_b} !== 12'd0) begin
      n_err++; $display("FAIL reset_b: got %h expected 0", {stall_b, bubble_b, ex_rs_sel_b, ex_rt_sel_b, id_sel_b, cnt_b});
    end
    n_vec++;
  endtask

  task automatic test_alu_fwd();
    apply_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0);
    @(negedge clk);
    if (stall !== 1'b0) begin n_err++; $display("FAIL alu_prod_stall: got %b expected 0", stall); end
    n_vec++;
    tick();
    drive(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0);
    @(negedge clk);
    if (stall !== 1'b0) begin n_err++; $display("FAIL alu_cons_stall: got %b expected 0", stall); end
    n_vec++;
    tick();
    idle();
    @(negedge clk);
    if (ex_rs_sel !== 2'd1) begin n_err++; $display("FAIL alu_rs_sel: got %0d expected 1", ex_rs_sel); end
    n_vec++;
    if (ex_rt_sel !== 2'd0) begin n_err++; $display("FAIL alu_rt_sel: got %0d expected 0", ex_rt_sel); end
    n_vec++;
  endtask

  task automatic test_load_use();
    apply_reset();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1);
    @(negedge clk);
    if (stall !== 1'b0) begin n_err++; $display("FAIL lu_load_stall: got %b expected 0", stall); end
    n_vec++;
    tick();
    drive(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0);
    @(negedge clk);
    if ({stall, bubble, stall_b} !== 3'b111) begin
      n_err++; $display("FAIL lu_first: got stall/bubble/stall_b %b expected 111", {stall, bubble, stall_b});
    end
    n_vec++;
    tick();
    @(negedge clk);
    if ({stall, stall_b} !== 2'b01) begin
      n_err++; $display("FAIL lu_second: got stall/stall_b %b expected 01", {stall, stall_b});
    end
    n_vec++;
    tick();
    @(negedge clk);
    if (ex_rt_sel !== 2'd2) begin n_err++; $display("FAIL lu_rt_sel: got %0d expected 2", ex_rt_sel); end
    n_vec++;
    if (ex_rs_sel !== 2'd0) begin n_err++; $display("FAIL lu_rs_sel: got %0d expected 0", ex_rs_sel); end
    n_vec++;
    if (stall_b !== 1'b0) begin n_err++; $display("FAIL lu_b_release: got %b expected 0", stall_b); end
    n_vec++;
    tick();
    idle();
    @(negedge clk);
    if (ex_rt_sel_b !== 2'd3) begin n_err++; $display("FAIL lu_b_rt_sel: got %0d expected 3", ex_rt_sel_b); end
    n_vec++;
    if ({cnt, cnt_b} !== {16'd1, 4'd2}) begin
      n_err++; $display("FAIL lu_counts: got %0d/%0d expected 1/2", cnt, cnt_b);
    end
    n_vec++;
  endtask

  task automatic test_youngest();
    apply_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0);
    tick();
    drive(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0);
    tick();
    drive(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0);
    @(negedge clk);
    if (stall !== 1'b0) begin n_err++; $display("FAIL yg_stall: got %b expected 0", stall); end
    n_vec++;
    tick();
    idle();
    @(negedge clk);
    if ({ex_rs_sel, ex_rt_sel} !== 4'b0101) begin
      n_err++; $display("FAIL yg_sels: got %0d/%0d expected 1/1", ex_rs_sel, ex_rt_sel);
    end
    n_vec++;
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0);
    tick();
    idle();
    @(negedge clk);
    if ({ex_rs_sel, ex_rt_sel} !== 4'b0000) begin
      n_err++; $display("FAIL r0_sels: got %0d/%0d expected 0/0", ex_rs_sel, ex_rt_sel);
    end
    n_vec++;
  endtask

  task automatic test_early_rs();
    int  n_stall;
    bit  done;
    int  exp_n;
    logic [1:0] exp_sel;
`ifdef ID_FWD_EN
    exp_n = 1; exp_sel = 2'd1;
`else
    exp_n = 4; exp_sel = 2'd0;
`endif
    apply_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0);
    tick();
    drive(1'b1, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    n_stall = 0;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
      else begin n_stall++; tick(); end
    end
    if (n_stall !== exp_n) begin n_err++; $display("FAIL early_cycles: got %0d expected %0d", n_stall, exp_n); end
    n_vec++;
    if (id_sel !== exp_sel) begin n_err++; $display("FAIL early_sel: got %0d expected %0d", id_sel, exp_sel); end
    n_vec++;
    if (cnt !== 16'(exp_n)) begin n_err++; $display("FAIL early_count: got %0d expected %0d", cnt, exp_n); end
    n_vec++;
    tick();
    idle();
  endtask

  task automatic test_flush_hold();
    apply_reset();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1);
    tick();
    drive(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    if ({stall, bubble, stall_b, bubble_b} !== 4'b0101) begin
      n_err++; $display("FAIL flush: got stall/bubble a,b %b expected 0101", {stall, bubble, stall_b, bubble_b});
    end
    n_vec++;
    tick();
    flush = 1'b0;
    @(negedge clk);
    if (stall !== 1'b0) begin n_err++; $display("FAIL post_flush_stall: got %b expected 0", stall); end
    n_vec++;
    tick();
    pipe_hold = 1'b1;
    drive(1'b1, 5'd6, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if ({stall, bubble, ex_rt_sel, cnt, cnt_b} !== {1'b0, 1'b0, 2'd2, 16'd0, 4'd1}) begin
        n_err++;
        $display("FAIL hold_%0d: got stall=%b bubble=%b rt_sel=%0d cnt=%0d cnt_b=%0d expected 0 0 2 0 1",
                 c, stall, bubble, ex_rt_sel, cnt, cnt_b);
      end
      n_vec++;
      tick();
    end
    pipe_hold = 1'b0;
    @(negedge clk);
    if ({stall, ex_rt_sel} !== 3'b110) begin
      n_err++; $display("FAIL hold_release: got stall=%b rt_sel=%0d expected 1 2", stall, ex_rt_sel);
    end
    n_vec++;
    tick();
    idle();
    @(negedge clk);
    if (cnt !== 16'd1) begin n_err++; $display("FAIL hold_count: got %0d expected 1", cnt); end
    n_vec++;
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1);
    tick();
    drive(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0);
    @(negedge clk);
    if (stall !== 1'b1) begin n_err++; $display("FAIL rms_pre: got %b expected 1", stall); end
    n_vec++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    if ({stall, bubble, ex_rs_sel, ex_rt_sel, id_sel, cnt} !== 24'd0) begin
      n_err++; $display("FAIL rms_after: got %h expected 0", {stall, bubble, ex_rs_sel, ex_rt_sel, id_sel, cnt});
    end
    n_vec++;
    idle();
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int it = 1; it <= 10; it++) begin
      drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1);
      tick();
      drive(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0);
      repeat (3) tick();
      if (it == 7) begin
        @(negedge clk);
        if (cnt_b !== 4'd14) begin n_err++; $display("FAIL sat_mid: got %0d expected 14", cnt_b); end
        n_vec++;
      end
    end
    idle();
    @(negedge clk);
    if (cnt_b !== 4'hF) begin n_err++; $display("FAIL sat_b: got %0d expected 15", cnt_b); end
    n_vec++;
    if (cnt !== 16'd10) begin n_err++; $display("FAIL sat_a: got %0d expected 10", cnt); end
    n_vec++;
  endtask

  task automatic test_random();
    logic       e_stall, e_bubble, hz, e_issue;
    logic [1:0] e_rs, e_rt, e_id;
    int         a;
    apply_reset();
    for (int a2 = 0; a2 <= DEPTH; a2++) m[a2] = '0;
    m_cnt = 16'd0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      reset     = ($urandom_range(0, 49) == 0);
      pipe_hold = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), $urandom_range(0, 2) == 0);
      @(negedge clk);
      hz = id_valid && ((id_use_rs && late(id_rs)) || (id_use_rt && late(id_rt)));
      e_id = 2'd0;
      a = youngest(id_rs, 0);
`ifdef ID_FWD_EN
      if (id_valid && id_early_rs && a >= 0) begin
        if (a >= 1 && a >= avail_age(m[a].ld)) e_id = 2'(a);
        else hz = 1'b1;
      end
`else
      if (id_valid && id_early_rs && a >= 0) hz = 1'b1;
`endif
      if (reset) e_id = 2'd0;
      e_stall  = !reset && !pipe_hold && !flush && hz;
      e_bubble = !reset && !pipe_hold && (flush || hz);
      e_rs = 2'd0;
      e_rt = 2'd0;
      if (!reset && m[0].v && m[0].urs && youngest(m[0].rs, 1) > 0) e_rs = 2'(youngest(m[0].rs, 1));
      if (!reset && m[0].v && m[0].urt && youngest(m[0].rt, 1) > 0) e_rt = 2'(youngest(m[0].rt, 1));
      if ({stall, bubble, ex_rs_sel, ex_rt_sel, id_sel, cnt} !== {e_stall, e_bubble, e_rs, e_rt, e_id, m_cnt}) begin
        n_err++;
        $display("FAIL rand cyc %0d: got st=%b bu=%b rs=%0d rt=%0d id=%0d cnt=%0d expected st=%b bu=%b rs=%0d rt=%0d id=%0d cnt=%0d",
                 cyc, stall, bubble, ex_rs_sel, ex_rt_sel, id_sel, cnt,
                 e_stall, e_bubble, e_rs, e_rt, e_id, m_cnt);
      end
      n_vec++;
      @(posedge clk);
      e_issue = id_valid && !e_stall && !flush;
      if (reset) begin
        for (int k = 0; k <= DEPTH; k++) m[k] = '0;
        m_cnt = 16'd0;
      end else if (!pipe_hold) begin
        for (int k = DEPTH; k >= 1; k--) m[k] = m[k-1];
        m[0] = e_issue ? {1'b1, id_wr_en, id_is_load, id_use_rs, id_use_rt, id_wr_addr, id_rs, id_rt} : '0;
        if (e_stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      #1;
    end
    reset = 1'b0; pipe_hold = 1'b0; flush = 1'b0;
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pipe_hold = 1'b0; flush = 1'b0;
    idle();
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_youngest();
    test_early_rs();
    test_flush_hold();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
